// File: rtl/ultracon_gen.sv
// AXI4-Lite control/readback for an array of miner units: command issue, status, serial FIFO drain.
// Define ULTRACON_OFLOW_STICKY_EN for sticky, write-1-to-clear overflow words.
module ultracon_gen #(
  parameter int unsigned BLOCKS     = 192,
  parameter int unsigned SHIFT_BITS = 180,
  parameter int unsigned REQ_LAT    = 9,
  parameter int unsigned ADDR_W     = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_axi_awaddr,
  input  logic              i_axi_awvalid,
  output logic              o_axi_awready,
  input  logic [31:0]       i_axi_wdata,
  input  logic [3:0]        i_axi_wstrb,
  input  logic              i_axi_wvalid,
  output logic              o_axi_wready,
  output logic [1:0]        o_axi_bresp,
  output logic              o_axi_bvalid,
  input  logic              i_axi_bready,
  input  logic [ADDR_W-1:0] i_axi_araddr,
  input  logic              i_axi_arvalid,
  output logic              o_axi_arready,
  output logic [31:0]       o_axi_rdata,
  output logic [1:0]        o_axi_rresp,
  output logic              o_axi_rvalid,
  input  logic              i_axi_rready,
  input  logic [BLOCKS-1:0] i_fifo_empty,
  input  logic [BLOCKS-1:0] i_fifo_oflow,
  input  logic [BLOCKS-1:0] i_fifo_bits,
  output logic [BLOCKS-1:0] o_fifo_req,
  output logic [19:0]       o_command,
  output logic [2:0]        o_opcode,
  output logic              o_turbo,
  output logic              o_strobe
);

  localparam int unsigned BLK_WORDS   = (BLOCKS + 31) / 32;
  localparam int unsigned BLK_PAD     = BLK_WORDS * 32;
  localparam int unsigned SHIFT_WORDS = (SHIFT_BITS + 31) / 32;
  localparam int unsigned SHIFT_PAD   = SHIFT_WORDS * 32;
  localparam int unsigned UNIT_W      = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
  localparam int unsigned CNT_MAX     = (SHIFT_BITS > REQ_LAT) ? SHIFT_BITS : REQ_LAT;
  localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);
  localparam int unsigned REG_CMD     = 32'h3C0;
  localparam int unsigned REG_STAT    = 32'h3C1;
  localparam logic [2:0]  OP_DRAIN    = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_SHIFT} state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_awready, r_bvalid, r_arready, r_rvalid;
  logic [31:0]           r_rdata, w_rdata;
  logic [BLOCKS-1:0]     r_empty, r_oflow, r_fifo_req;
  logic [SHIFT_BITS-1:0] r_shift;
  logic [SHIFT_BITS:0]   w_shift_cat;
  logic [UNIT_W-1:0]     r_unit;
  logic [19:0]           r_command;
  logic [2:0]            r_opcode;
  logic                  r_turbo, r_strobe, r_bad, r_done, r_reject;
  logic                  w_wr_hs, w_wr_en, w_cmd_wr, w_stat_wr, w_drain_req, w_unit_ok;
  logic                  w_set_done, w_set_bad, w_set_reject, w_busy;
  logic [BLK_PAD-1:0]    w_empty_pad, w_oflow_pad;
  logic [SHIFT_PAD-1:0]  w_shift_pad;
  int unsigned           w_aw_idx, w_ar_idx, w_ar_word;
  logic                  w_unused_ok;

  assign o_axi_awready = r_awready;
  assign o_axi_wready  = r_awready;
  assign o_axi_bvalid  = r_bvalid;
  assign o_axi_bresp   = 2'b00;
  assign o_axi_arready = r_arready;
  assign o_axi_rvalid  = r_rvalid;
  assign o_axi_rdata   = r_rdata;
  assign o_axi_rresp   = 2'b00;
  assign o_fifo_req    = r_fifo_req;
  assign o_command     = r_command;
  assign o_opcode      = r_opcode;
  assign o_turbo       = r_turbo;
  assign o_strobe      = r_strobe;

  assign w_unused_ok = ^{i_axi_wdata[31:29], i_axi_wdata[27], i_axi_wdata[23:20]};

  // Write decode; a zero byte strobe completes the handshake but changes nothing
  assign w_wr_hs     = r_awready & i_axi_awvalid & i_axi_wvalid;
  assign w_wr_en     = w_wr_hs & (|i_axi_wstrb);
  assign w_aw_idx    = 32'(i_axi_awaddr) >> 2;
  assign w_cmd_wr    = w_wr_en && (w_aw_idx == REG_CMD);
  assign w_stat_wr   = w_wr_en && (w_aw_idx == REG_STAT);
  assign w_drain_req = w_cmd_wr && (i_axi_wdata[26:24] == OP_DRAIN);
  assign w_unit_ok   = 32'(i_axi_wdata[9:0]) < BLOCKS;
  assign w_busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_awready <= i_axi_awvalid & i_axi_wvalid & ~r_bvalid & ~r_awready;
      if (w_wr_hs)           r_bvalid <= 1'b1;
      else if (i_axi_bready) r_bvalid <= 1'b0;
      if (r_arready && i_axi_arvalid) begin
        r_rvalid  <= 1'b1;
        r_arready <= 1'b0;
        r_rdata   <= w_rdata;
      end else if (r_rvalid && i_axi_rready) begin
        r_rvalid  <= 1'b0;
        r_arready <= 1'b1;
      end else begin
        r_arready <= ~r_rvalid;
      end
    end
  end

  assign w_empty_pad = BLK_PAD'(r_empty);
  assign w_oflow_pad = BLK_PAD'(r_oflow);
  assign w_shift_pad = SHIFT_PAD'(r_shift);
  assign w_ar_idx    = 32'(i_axi_araddr) >> 2;
  assign w_ar_word   = w_ar_idx & 32'hFF;

  always_comb begin
    w_rdata = '0;
    case (w_ar_idx >> 8)
      32'd0: if (w_ar_word < BLK_WORDS)   w_rdata = w_empty_pad[w_ar_word*32 +: 32];
      32'd1: if (w_ar_word < BLK_WORDS)   w_rdata = w_oflow_pad[w_ar_word*32 +: 32];
      32'd2: if (w_ar_word < SHIFT_WORDS) w_rdata = w_shift_pad[w_ar_word*32 +: 32];
      32'd3: begin
        if (w_ar_idx == REG_CMD)
          w_rdata = {3'b0, r_turbo, 1'b0, r_opcode, 4'b0, r_command};
        else if (w_ar_idx == REG_STAT)
          w_rdata = {w_busy, 28'b0, r_reject, r_done, r_bad};
      end
      default: w_rdata = '0;
    endcase
  end

`ifdef ULTRACON_OFLOW_STICKY_EN
  logic [BLOCKS-1:0] w_oflow_clr;

  always_comb begin
    w_oflow_clr = '0;
    if (w_wr_en && ((w_aw_idx >> 8) == 32'd1)) begin
      for (int b = 0; b < int'(BLOCKS); b++)
        if (32'(b / 32) == (w_aw_idx & 32'hFF)) w_oflow_clr[b] = i_axi_wdata[b % 32];
    end
  end

  // Live overflow sets the sticky bit even when a clear lands in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_oflow <= '0;
    else       r_oflow <= (r_oflow & ~w_oflow_clr) | i_fifo_oflow;
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_oflow <= '0;
    else       r_oflow <= i_fifo_oflow;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_empty   <= '0;
      r_command <= '0;
      r_opcode  <= '0;
      r_turbo   <= 1'b0;
      r_strobe  <= 1'b0;
      r_bad     <= 1'b0;
      r_done    <= 1'b0;
      r_reject  <= 1'b0;
    end else begin
      r_empty <= i_fifo_empty;
      if (w_cmd_wr) begin
        r_turbo   <= i_axi_wdata[28];
        r_opcode  <= i_axi_wdata[26:24];
        r_command <= i_axi_wdata[19:0];
        r_strobe  <= ~r_strobe;
      end
      r_bad    <= w_set_bad    | (r_bad    & ~(w_stat_wr & i_axi_wdata[0]));
      r_done   <= w_set_done   | (r_done   & ~(w_stat_wr & i_axi_wdata[1]));
      r_reject <= w_set_reject | (r_reject & ~(w_stat_wr & i_axi_wdata[2]));
    end
  end

  // Drain sequencer: one request pulse, latency wait, then SHIFT_BITS serial samples
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_set_done   = 1'b0;
    w_set_bad    = 1'b0;
    w_set_reject = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_drain_req) begin
          if (w_unit_ok) w_state_nxt = S_REQ;
          else           w_set_bad   = 1'b1;
        end
      end
      S_REQ: begin
        w_cnt_nxt   = '0;
        w_state_nxt = (REQ_LAT == 1) ? S_SHIFT : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == CNT_W'(REQ_LAT - 2)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CNT_W'(SHIFT_BITS - 1)) begin
          w_set_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if ((r_state != S_IDLE) && w_drain_req) w_set_reject = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_shift_cat = {i_fifo_bits[r_unit], r_shift};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fifo_req <= '0;
      r_unit     <= '0;
      r_shift    <= '0;
    end else begin
      r_fifo_req <= '0;
      if ((r_state == S_IDLE) && (w_state_nxt == S_REQ)) begin
        r_unit     <= UNIT_W'(i_axi_wdata[9:0]);
        r_fifo_req <= BLOCKS'(1) << i_axi_wdata[9:0];
      end
      if (r_state == S_REQ)        r_shift <= '0;
      else if (r_state == S_SHIFT) r_shift <= w_shift_cat[SHIFT_BITS:1];
    end
  end

endmodule

// File: tb/tb_ultracon_gen.sv
// Directed bench for ultracon_gen: AXI-Lite register access, status sticky bits and unit drain.
module tb_ultracon_gen;

  localparam int unsigned BLOCKS     = 192;
  localparam int unsigned SHIFT_BITS = 180;
  localparam int unsigned REQ_LAT    = 9;
  localparam int unsigned ADDR_W     = 12;

  logic              clk, reset;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic              awvalid, awready, wready, wvalid, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [31:0]       wdata, rdata;
  logic [3:0]        wstrb;
  logic [1:0]        bresp, rresp;
  logic [BLOCKS-1:0] fifo_empty, fifo_oflow, fifo_bits, fifo_req;
  logic [19:0]       command;
  logic [2:0]        opcode;
  logic              turbo, strobe;

  int          n_checks = 0;
  int          n_errors = 0;
  int          req_pulses;
  logic [BLOCKS-1:0] req_last;
  logic [7:0]  pat = 8'hA5;
  logic [31:0] rd;
  logic [1:0]  resp;

  ultracon_gen #(.BLOCKS(BLOCKS), .SHIFT_BITS(SHIFT_BITS), .REQ_LAT(REQ_LAT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .i_axi_awaddr(awaddr), .i_axi_awvalid(awvalid), .o_axi_awready(awready),
    .i_axi_wdata(wdata), .i_axi_wstrb(wstrb), .i_axi_wvalid(wvalid), .o_axi_wready(wready),
    .o_axi_bresp(bresp), .o_axi_bvalid(bvalid), .i_axi_bready(bready),
    .i_axi_araddr(araddr), .i_axi_arvalid(arvalid), .o_axi_arready(arready),
    .o_axi_rdata(rdata), .o_axi_rresp(rresp), .o_axi_rvalid(rvalid), .i_axi_rready(rready),
    .i_fifo_empty(fifo_empty), .i_fifo_oflow(fifo_oflow), .i_fifo_bits(fifo_bits),
    .o_fifo_req(fifo_req), .o_command(command), .o_opcode(opcode), .o_turbo(turbo), .o_strobe(strobe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    chk("aw_accept", 32'(awready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    chk("b_valid", 32'(bvalid), 32'd1);
    r = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
    int n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    if (!rvalid) chk("r_valid", 32'(rvalid), 32'd1);
    d = rdata;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  // Unit 7: serial pattern starting REQ_LAT cycles after its request cycle
  initial begin
    fifo_bits = '0;
    forever begin
      @(negedge clk);
      if (fifo_req[7]) begin
        repeat (REQ_LAT) @(posedge clk);
        for (int i = 0; i < int'(SHIFT_BITS); i++) begin
          #1 fifo_bits[7] = pat[i % 8];
          @(posedge clk);
        end
        #1 fifo_bits[7] = 1'b0;
      end
    end
  end

  initial begin
    req_pulses = 0;
    req_last   = '0;
    forever begin
      @(negedge clk);
      if (fifo_req != '0) begin
        req_pulses++;
        req_last = fifo_req;
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    fifo_empty = '0; fifo_oflow = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_fifo_req", 32'(|fifo_req), 32'd0);
    chk("rst_strobe", 32'(strobe), 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    axi_read(12'hF04, rd); chk("status_rst", rd, 32'h0);
    axi_read(12'hF00, rd); chk("cmd_rst", rd, 32'h0);

    axi_write(12'hF00, 32'h1300ABCD, 4'hF, resp);
    chk("bresp", 32'(resp), 32'd0);
    chk("turbo", 32'(turbo), 32'd1);
    chk("opcode", 32'(opcode), 32'd3);
    chk("command", 32'(command), 32'h0ABCD);
    chk("strobe_1", 32'(strobe), 32'd1);
    axi_read(12'hF00, rd); chk("cmd_rb", rd, 32'h1300ABCD);
    axi_read(12'hF04, rd); chk("status_op3", rd, 32'h0);
    chk("no_req_op3", 32'(req_pulses), 32'd0);

    axi_write(12'hF00, 32'hFFFFFFFF, 4'h0, resp);
    chk("strobe_wstrb0", 32'(strobe), 32'd1);
    axi_read(12'hF00, rd); chk("cmd_wstrb0", rd, 32'h1300ABCD);

    fifo_empty[191] = 1'b1; fifo_empty[0] = 1'b1; fifo_empty[33] = 1'b1;
    repeat (2) @(posedge clk); #1;
    axi_read(12'h014, rd); chk("empty_w5", rd, 32'h80000000);
    axi_read(12'h018, rd); chk("empty_w6", rd, 32'h0);
    axi_read(12'h000, rd); chk("empty_w0", rd, 32'h00000001);
    axi_read(12'h004, rd); chk("empty_w1", rd, 32'h00000002);
    axi_read(12'hC00, rd); chk("unmapped", rd, 32'h0);

    fifo_oflow[3] = 1'b1;
    repeat (2) @(posedge clk); #1;
    axi_read(12'h400, rd); chk("oflow_live", rd, 32'h8);
    fifo_oflow[3] = 1'b0;
    repeat (2) @(posedge clk); #1;
`ifdef ULTRACON_OFLOW_STICKY_EN
    axi_read(12'h400, rd); chk("oflow_sticky", rd, 32'h8);
    axi_write(12'h400, 32'h8, 4'hF, resp);
    axi_read(12'h400, rd); chk("oflow_clear", rd, 32'h0);
`else
    axi_read(12'h400, rd); chk("oflow_drop", rd, 32'h0);
`endif

    axi_write(12'hF00, 32'h050000C8, 4'hF, resp);
    axi_read(12'hF04, rd); chk("bad_unit", rd, 32'h1);
    chk("no_req_bad", 32'(req_pulses), 32'd0);
    axi_write(12'hF04, 32'h1, 4'hF, resp);
    axi_read(12'hF04, rd); chk("bad_w1c", rd, 32'h0);

    axi_write(12'hF00, 32'h05000007, 4'hF, resp);
    axi_read(12'hF04, rd); chk("busy", rd, 32'h80000000);
    axi_write(12'hF00, 32'h05000003, 4'hF, resp);
    chk("cmd_while_busy", 32'(command), 32'h3);
    axi_read(12'hF04, rd); chk("reject", rd, 32'h80000004);
    n = 0;
    do begin
      axi_read(12'hF04, rd);
      n++;
    end while (rd[31] && n < 200);
    chk("drain_done", rd, 32'h6);
    chk("req_pulses", 32'(req_pulses), 32'd1);
    chk("req_onehot", 32'(req_last == (BLOCKS'(1) << 7)), 32'd1);
    for (int k = 0; k < 5; k++) begin
      axi_read(12'(12'h800 + 4 * k), rd);
      chk($sformatf("shift_w%0d", k), rd, 32'hA5A5A5A5);
    end
    axi_read(12'h814, rd); chk("shift_w5", rd, 32'h0005A5A5);
    axi_read(12'h818, rd); chk("shift_w6", rd, 32'h0);
    axi_write(12'hF04, 32'h2, 4'hF, resp);
    axi_read(12'hF04, rd); chk("done_w1c", rd, 32'h4);
    axi_write(12'hF04, 32'h4, 4'hF, resp);
    axi_read(12'hF04, rd); chk("reject_w1c", rd, 32'h0);

    axi_write(12'hF00, 32'h05000007, 4'hF, resp);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_strobe", 32'(strobe), 32'd0);
    chk("async_fifo_req", 32'(|fifo_req), 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    axi_read(12'hF04, rd); chk("status_after_rst", rd, 32'h0);
    axi_read(12'hF00, rd); chk("cmd_after_rst", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
